// File: rtl/result_tx_pkg.sv
// Shared constants and FSM state type for the result_tx serial transmitter.
// Define RESULT_TX_PARITY_EN to add an even-parity bit to every frame.
package result_tx_pkg;

    localparam int DATA_BITS = 8;
    localparam logic IDLE_LEVEL = 1'b1;

`ifdef RESULT_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    localparam int FRAME_BITS = 10;
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

endpackage

// File: rtl/result_fifo.sv
// Synchronous byte FIFO with wrapping pointers and an occupancy count.
// full/empty are registered and derived from the next occupancy.
module result_fifo #(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [7:0]       wdata,
    input  logic             pop,
    output logic [7:0]       rdata,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [7:0]       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count_next;

    always_comb begin
        count_next = count;
        if (push && !pop) begin
            count_next = count + 1'b1;
        end else if (pop && !push) begin
            count_next = count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count_next;
            full  <= (count_next == CNT_W'(DEPTH));
            empty <= (count_next == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wdata;
    end

    // Head of queue is visible combinationally so the FSM can load it on the pop edge.
    assign rdata = mem[rd_ptr];

endmodule

// File: rtl/result_tx.sv
// Result byte transmitter: queued bytes are sent as start/8 data/stop frames, LSB first.
// Define RESULT_TX_PARITY_EN to insert an even-parity bit after data bit 7.
module result_tx
    import result_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] data_in,
    input  logic       valid_in,
    output logic       ready_out,
    output logic       tx,
    output logic       busy
);
    localparam int         CNT_W     = $clog2(FIFO_DEPTH + 1);
    localparam logic [7:0] LAST_TICK = 8'(CLKS_PER_BIT - 1);
    localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);

    state_t           state;
    logic [7:0]       bit_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift_reg;
    logic             fifo_full;
    logic             fifo_empty;
    logic [7:0]       fifo_rdata;
    logic [CNT_W-1:0] fifo_count;
    logic             push;
    logic             pop;
    logic             bit_done;
`ifdef RESULT_TX_PARITY_EN
    logic             parity_bit;
`endif

    result_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .wdata (data_in),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign ready_out = ~fifo_full;
    assign push      = valid_in & ready_out & ~reset;
    assign bit_done  = (bit_cnt == LAST_TICK);
    // A new frame is loaded from idle, or straight out of the last stop tick.
    assign pop       = ~reset & ~fifo_empty & ((state == IDLE) | ((state == STOP) & bit_done));

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            tx         <= IDLE_LEVEL;
            busy       <= 1'b0;
            bit_cnt    <= '0;
            bit_idx    <= '0;
            shift_reg  <= '0;
`ifdef RESULT_TX_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else if (pop) begin
            state      <= START;
            tx         <= 1'b0;
            busy       <= 1'b1;
            bit_cnt    <= '0;
            bit_idx    <= '0;
            shift_reg  <= fifo_rdata;
`ifdef RESULT_TX_PARITY_EN
            parity_bit <= ^fifo_rdata;
`endif
        end else begin
            case (state)
                IDLE: begin
                    bit_cnt <= '0;
                    busy    <= (fifo_count != '0) | push;
                end
                START: begin
                    if (bit_done) begin
                        bit_cnt <= '0;
                        state   <= DATA;
                        tx      <= shift_reg[0];
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (bit_done) begin
                        bit_cnt <= '0;
                        if (bit_idx == LAST_BIT) begin
`ifdef RESULT_TX_PARITY_EN
                            state <= PARITY;
                            tx    <= parity_bit;
`else
                            state <= STOP;
                            tx    <= IDLE_LEVEL;
`endif
                        end else begin
                            bit_idx   <= bit_idx + 1'b1;
                            shift_reg <= shift_reg >> 1;
                            tx        <= shift_reg[1];
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
`ifdef RESULT_TX_PARITY_EN
                PARITY: begin
                    if (bit_done) begin
                        bit_cnt <= '0;
                        state   <= STOP;
                        tx      <= IDLE_LEVEL;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (bit_done) begin
                        bit_cnt <= '0;
                        state   <= IDLE;
                        busy    <= push;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    tx    <= IDLE_LEVEL;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_result_tx.sv
// Bench for result_tx: a timing/occupancy model predicts each frame; a serial monitor decodes tx.
// Works with or without RESULT_TX_PARITY_EN.
module tb_result_tx;
    import result_tx_pkg::*;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int FL    = FRAME_BITS * CPB;

    logic       clk;
    logic       reset;
    logic [7:0] data_in;
    logic       valid_in;
    logic       ready_out;
    logic       tx;
    logic       busy;

    result_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .data_in   (data_in),
        .valid_in  (valid_in),
        .ready_out (ready_out),
        .tx        (tx),
        .busy      (busy)
    );

    // ---------------- clock / counters ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Frame for a byte accepted at edge a starts at max(a+1, end of previous frame)
    // and lasts FL cycles; the byte occupies the queue until its frame starts.
    int         cyc        = 0;
    int         pend[$];
    logic [7:0] exp_q[$];
    int         exp_start_q[$];
    int         frame_end  = 0;
    int         tail_end   = 0;
    int         cur_start  = 0;
    int         rst_gen    = 0;
    int         s;
    bit         model_on   = 0;
    bit         m_accepted = 0;
    bit         ready_exp  = 1;
    bit         busy_exp   = 0;

    always @(posedge clk) begin
        cyc++;
        m_accepted = 0;
        if (reset) begin
            pend.delete();
            exp_q.delete();
            exp_start_q.delete();
            frame_end = cyc;
            tail_end  = cyc;
            model_on  = 1;
            rst_gen++;
        end else if (model_on) begin
            if (valid_in && pend.size() < DEPTH) begin
                s = (cyc + 1 > tail_end) ? cyc + 1 : tail_end;
                tail_end = s + FL;
                pend.push_back(s);
                exp_q.push_back(data_in);
                exp_start_q.push_back(s);
                m_accepted = 1;
            end
            if (pend.size() > 0 && pend[0] == cyc) begin
                void'(pend.pop_front());
                frame_end = cyc + FL;
                cur_start = cyc;
            end
        end
        ready_exp = (pend.size() < DEPTH);
        busy_exp  = (cyc < frame_end) || (pend.size() > 0);
    end

    always @(negedge clk) begin
        if (model_on) begin
            check("ready_out", 32'(ready_out), 32'(ready_exp));
            check("busy", 32'(busy), 32'(busy_exp));
        end
    end

    // ---------------- serial monitor / scoreboard ----------------
    task automatic receive_frame();
        logic [FRAME_BITS-1:0] bits;
        logic [7:0]            exp_d;
        int                    exp_s;
        bit                    hold_ok = 1;
        int                    start   = cyc;
        int                    gen     = rst_gen;
        bits = '0;
        for (int b = 0; b < FRAME_BITS; b++) begin
            for (int t = 0; t < CPB; t++) begin
                if (!(b == 0 && t == 0)) @(negedge clk);
                if (rst_gen != gen) return;
                if (t == 0) bits[b] = tx;
                else if (tx !== bits[b]) hold_ok = 0;
            end
        end
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_frame: got data 0x%0h at cycle %0d, none expected", bits[8:1], start);
            return;
        end
        exp_d = exp_q.pop_front();
        exp_s = exp_start_q.pop_front();
        check("frame_start", 32'(start), 32'(exp_s));
        check("frame_data", 32'(bits[8:1]), 32'(exp_d));
        check("bit_hold", 32'(hold_ok), 32'd1);
        check("stop_bit", 32'(bits[FRAME_BITS-1]), 32'd1);
`ifdef RESULT_TX_PARITY_EN
        check("parity_bit", 32'(bits[9]), 32'(^exp_d));
`endif
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (model_on && !reset && tx === 1'b0) receive_frame();
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_byte(input logic [7:0] d);
        int waited = 0;
        data_in  = d;
        valid_in = 1'b1;
        do begin
            @(negedge clk);
            waited++;
        end while (!m_accepted && waited < 2000);
        if (!m_accepted) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: byte 0x%0h not accepted after %0d cycles", d, waited);
        end
    endtask

    task automatic wait_idle();
        int waited = 0;
        valid_in = 1'b0;
        while ((busy_exp || exp_q.size() != 0) && waited < 20000) begin
            @(negedge clk);
            waited++;
        end
        if (busy_exp || exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL idle_timeout: %0d bytes still pending", exp_q.size());
        end
        repeat (3) @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int waited;
        reset    = 1'b1;
        valid_in = 1'b0;
        data_in  = 8'h00;
        repeat (3) @(negedge clk);
        check("reset_tx", 32'(tx), 32'd1);
        reset = 1'b0;
        @(negedge clk);

        // single byte, then back-to-back pair
        send_byte(8'hA5);
        wait_idle();
        send_byte(8'h00);
        send_byte(8'hFF);
        wait_idle();

        // hold valid through a full queue; 0x99 waits for a pop to free a slot
        for (int i = 1; i <= 6; i++) send_byte(8'(i));
        send_byte(8'h99);
        wait_idle();

        send_byte(8'h07);
        wait_idle();

        // reset during data bit 3 of 0x3C with two bytes queued
        send_byte(8'h3C);
        send_byte(8'h11);
        send_byte(8'h22);
        valid_in = 1'b0;
        waited = 0;
        while (cyc < cur_start + 4 * CPB + 1 && waited < 1000) begin
            @(negedge clk);
            waited++;
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mid_reset_tx", 32'(tx), 32'd1);
        repeat (100) @(negedge clk);
        check("after_reset_tx", 32'(tx), 32'd1);

        // randomized bytes with random idle gaps
        for (int i = 0; i < 120; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                valid_in = 1'b0;
                data_in  = 8'($urandom);
                repeat ($urandom_range(1, 60)) @(negedge clk);
            end
            send_byte(8'($urandom));
        end
        wait_idle();

        check("drain_empty", 32'(exp_q.size()), 32'd0);
        check("final_tx", 32'(tx), 32'd1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
